// File: rtl/mem_access_ctrl.sv
// Memory access controller: accepts one load or store request at a time and
// runs it against a synchronous single-port RAM with a registered read port.
// Addresses at or above ADDR_LIMIT complete at once with err set and no RAM
// strobe issued.
module mem_access_ctrl #(
  parameter int unsigned ADDR_LIMIT = 512
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_dout,
  input  logic [31:0] mem_din
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_CAP  = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Unsigned 32-bit compare, so 0xFFFFFFFF is simply too large and never wraps.
  localparam logic [31:0] LIMIT = 32'(ADDR_LIMIT);

  state_t state;
  state_t next_state;
  logic   in_range;
  logic   accept;

  assign in_range = (addr < LIMIT);
  assign accept   = (state == IDLE) && req;
  assign busy     = (state != IDLE);

  // State register; clear forces IDLE immediately, aborting any access.
  // NOTE: sequential state is updated with non-blocking (<=) assignments so
  // every register samples the pre-edge values of its inputs.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; req is only looked at while IDLE.
  // NOTE: next_state gets a default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (!in_range) next_state = DONE;
          else if (we)   next_state = WR;
          else           next_state = RD_ADDR;
        end
      end
      RD_ADDR: next_state = RD_CAP;
      RD_CAP:  next_state = DONE;
      WR:      next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered strobes and status: each is high exactly in the state it
  // belongs to, so they are computed from next_state one edge ahead.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      done      <= 1'b0;
      err       <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      done      <= (next_state == DONE);
      err       <= accept && !in_range;
      mem_read  <= (next_state == RD_ADDR);
      mem_write <= (next_state == WR);
    end
  end

  // Request latch: address and store data are held until the next acceptance,
  // including out-of-range ones (no strobe goes with those).
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      mem_addr <= '0;
      mem_dout <= '0;
    end else if (accept) begin
      mem_addr <= addr;
      mem_dout <= wdata;
    end
  end

  // Load result: RAM Q is valid in RD_CAP, captured on the edge leaving it.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear)                rdata <= '0;
    else if (state == RD_CAP)  rdata <= mem_din;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural registered-read RAM.
// Inputs change and outputs are sampled at the falling clock edge.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        clear;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;

  int n_cmp = 0;
  int n_bad = 0;

  // RAM model: 512 words, synchronous write, registered read data.
  logic [31:0] ram [0:511];
  logic        pre_we = 1'b0;
  logic [8:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_LIMIT(512)) dut (
    .clk       (clk),
    .clear     (clear),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din)
  );

  always @(posedge clk) begin
    if (pre_we)
      ram[pre_addr] <= pre_data;
    else if (mem_write && mem_addr < 32'd512)
      ram[mem_addr[8:0]] <= mem_dout;
    if (mem_read && mem_addr < 32'd512)
      mem_din <= ram[mem_addr[8:0]];
  end

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({busy, done, err, mem_read, mem_write} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: busy/done/err/rd/wr=%b expected 00000",
               {busy, done, err, mem_read, mem_write});
    end
    n_cmp++;
    if ({rdata, mem_addr, mem_dout} !== 96'b0) begin
      n_bad++;
      $display("FAIL reset_data: rdata=%h mem_addr=%h mem_dout=%h expected all 0",
               rdata, mem_addr, mem_dout);
    end
  endtask

  task automatic test_store();
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h87; wdata = 32'hDEADBEEF;
    @(negedge clk);                       // cycle N+1: WR
    req = 1'b0;
    n_cmp++;
    if ({mem_write, mem_read, busy} !== 3'b101) begin
      n_bad++;
      $display("FAIL store_wr_strobe: wr/rd/busy=%b expected 101", {mem_write, mem_read, busy});
    end
    n_cmp++;
    if (mem_addr !== 32'h87 || mem_dout !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL store_wr_bus: mem_addr=%h mem_dout=%h expected 00000087 deadbeef",
               mem_addr, mem_dout);
    end
    @(negedge clk);                       // cycle N+2: DONE
    n_cmp++;
    if ({done, err, mem_write, busy} !== 4'b1001) begin
      n_bad++;
      $display("FAIL store_done: done/err/wr/busy=%b expected 1001", {done, err, mem_write, busy});
    end
    @(negedge clk);                       // back in IDLE
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL store_idle: done/busy=%b expected 00", {done, busy});
    end
    n_cmp++;
    if (ram[9'h87] !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL store_ram: ram[87]=%h expected deadbeef", ram[9'h87]);
    end
    n_cmp++;
    if (mem_addr !== 32'h87 || mem_dout !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL store_hold: mem_addr=%h mem_dout=%h expected held values", mem_addr, mem_dout);
    end
  endtask

  // One access, observed for 6 cycles after acceptance.
  task automatic run_access(input string name, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input int exp_done_cyc,
                            input logic exp_err, input int exp_reads,
                            input int exp_writes, input logic [31:0] exp_rdata);
    int done_cyc, dones, reads, writes, overlap;
    logic err_seen;
    done_cyc = 0; dones = 0; reads = 0; writes = 0; overlap = 0; err_seen = 1'b0;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) req = 1'b0;
      if (mem_read)  reads++;
      if (mem_write) writes++;
      if (mem_read && mem_write) overlap++;
      if (done) begin
        dones++;
        if (done_cyc == 0) begin
          done_cyc = k;
          err_seen = err;
        end
      end
    end
    n_cmp++;
    if (done_cyc !== exp_done_cyc || dones !== 1) begin
      n_bad++;
      $display("FAIL %s_done: done at cycle %0d (%0d pulses) expected cycle %0d (1 pulse)",
               name, done_cyc, dones, exp_done_cyc);
    end
    n_cmp++;
    if (err_seen !== exp_err) begin
      n_bad++;
      $display("FAIL %s_err: err=%b expected %b", name, err_seen, exp_err);
    end
    n_cmp++;
    if (reads !== exp_reads || writes !== exp_writes || overlap !== 0) begin
      n_bad++;
      $display("FAIL %s_strobes: reads=%0d writes=%0d overlap=%0d expected %0d %0d 0",
               name, reads, writes, overlap, exp_reads, exp_writes);
    end
    n_cmp++;
    if (rdata !== exp_rdata || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_rdata: rdata=%h busy=%b expected %h 0", name, rdata, busy, exp_rdata);
    end
  endtask

  task automatic test_load();
    run_access("load_95", 1'b0, 32'h95, 32'h0, 3, 1'b0, 1, 0, 32'h12345678);
  endtask

  task automatic test_range();
    run_access("load_511", 1'b0, 32'd511, 32'h0, 3, 1'b0, 1, 0, 32'hA5A50001);
    run_access("load_512", 1'b0, 32'd512, 32'h0, 1, 1'b1, 0, 0, 32'hA5A50001);
    run_access("load_ffff", 1'b0, 32'hFFFFFFFF, 32'h0, 1, 1'b1, 0, 0, 32'hA5A50001);
    run_access("store_512", 1'b1, 32'd512, 32'h77777777, 1, 1'b1, 0, 0, 32'hA5A50001);
  endtask

  task automatic test_back_to_back();
    logic [7:1] bz, rd, wr, dn;
    bz = '0; rd = '0; wr = '0; dn = '0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'hCAFEF00D;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      bz[k] = busy; rd[k] = mem_read; wr[k] = mem_write; dn[k] = done;
      if (k == 1) we = 1'b0;              // req stays high: next access is a load
      if (k == 4) req = 1'b0;
      if (k == 6) begin
        n_cmp++;
        if (rdata !== 32'hCAFEF00D) begin
          n_bad++;
          $display("FAIL b2b_rdata: rdata=%h expected cafef00d", rdata);
        end
      end
    end
    n_cmp++;
    if (bz !== 7'b0111011) begin
      n_bad++;
      $display("FAIL b2b_busy: busy cycles 7..1=%b expected 0111011", bz);
    end
    n_cmp++;
    if (wr !== 7'b0000001 || rd !== 7'b0001000) begin
      n_bad++;
      $display("FAIL b2b_strobes: wr=%b rd=%b expected 0000001 0001000", wr, rd);
    end
    n_cmp++;
    if (dn !== 7'b0100010) begin
      n_bad++;
      $display("FAIL b2b_done: done cycles 7..1=%b expected 0100010", dn);
    end
  endtask

  task automatic test_reset_mid_store();
    int dones;
    dones = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h0F0F0F0F;
    @(negedge clk);                       // in WR
    req = 1'b0;
    n_cmp++;
    if (mem_write !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_pre: mem_write=%b expected 1", mem_write);
    end
    #1 clear = 1'b0;
    #1;                                   // well before the next rising edge
    n_cmp++;
    if ({mem_write, busy, done} !== 3'b000 || mem_addr !== 32'h0 || mem_dout !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_mid_async: wr/busy/done=%b mem_addr=%h mem_dout=%h expected 000 0 0",
               {mem_write, busy, done}, mem_addr, mem_dout);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    clear = 1'b1;
    req = 1'b1; we = 1'b1; addr = 32'h11; wdata = 32'h0BADC0DE;
    @(negedge clk);
    req = 1'b0;
    n_cmp++;
    if (mem_write !== 1'b1 || mem_addr !== 32'h11 || mem_dout !== 32'h0BADC0DE) begin
      n_bad++;
      $display("FAIL rst_after_wr: wr=%b mem_addr=%h mem_dout=%h expected 1 00000011 0badc0de",
               mem_write, mem_addr, mem_dout);
    end
    @(negedge clk);
    if (done) dones++;
    n_cmp++;
    if (dones !== 1 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_done_count: done pulses=%0d err=%b expected 1 0", dones, err);
    end
    @(negedge clk);
    n_cmp++;
    if (ram[9'h10] !== 32'h5555AAAA || ram[9'h11] !== 32'h0BADC0DE) begin
      n_bad++;
      $display("FAIL rst_ram: ram[10]=%h ram[11]=%h expected 5555aaaa 0badc0de",
               ram[9'h10], ram[9'h11]);
    end
  endtask

  task automatic test_busy_block();
    int writes;
    writes = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h20; wdata = 32'h0;
    @(negedge clk);                       // RD_ADDR
    req = 1'b0;
    @(negedge clk);                       // RD_CAP: disturb inputs
    req = 1'b1; we = 1'b1; addr = 32'h21; wdata = 32'hFFFF0000;
    @(negedge clk);                       // DONE
    if (mem_write) writes++;
    n_cmp++;
    if (done !== 1'b1 || rdata !== 32'h11112222 || mem_addr !== 32'h20) begin
      n_bad++;
      $display("FAIL busy_blk_done: done=%b rdata=%h mem_addr=%h expected 1 11112222 00000020",
               done, rdata, mem_addr);
    end
    req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (mem_write) writes++;
    end
    n_cmp++;
    if (writes !== 0 || busy !== 1'b0 || ram[9'h21] !== 32'h33334444) begin
      n_bad++;
      $display("FAIL busy_blk_ignored: writes=%0d busy=%b ram[21]=%h expected 0 0 33334444",
               writes, busy, ram[9'h21]);
    end
  endtask

  initial begin
    clear = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    #2;
    test_reset();
    preload(9'h095, 32'h12345678);
    preload(9'h1FF, 32'hA5A50001);
    preload(9'h010, 32'h5555AAAA);
    preload(9'h011, 32'h00000000);
    preload(9'h020, 32'h11112222);
    preload(9'h021, 32'h33334444);
    preload(9'h087, 32'h00000000);
    test_reset();
    clear = 1'b1;
    test_store();
    test_load();
    test_range();
    test_back_to_back();
    test_reset_mid_store();
    test_busy_block();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: ADDR_LIMIT, default 512, number of valid word addresses in the attached RAM.
REQ-002 clk  in  1  single clock; all state changes occur on its rising edge.
REQ-003 clear  in  1  reset, asynchronous, active-low.
REQ-004 req  in  1  datapath access request; sampled only in IDLE.
REQ-005 we  in  1  access type: 1 = store, 0 = load; sampled with req.
REQ-006 addr  in  32  word address; sampled with req.
REQ-007 wdata  in  32  store data; sampled with req.
REQ-008 busy  out  1  high while an access is in progress, from the cycle after acceptance through DONE.
REQ-009 done  out  1  single-cycle completion pulse.
REQ-010 err  out  1  out-of-range flag for the access completing this cycle; valid only with done.
REQ-011 rdata  out  32  load result; held until the next successful load.
REQ-012 mem_addr  out  32  RAM address.
REQ-013 mem_read  out  1  RAM read strobe.
REQ-014 mem_write  out  1  RAM write strobe.
REQ-015 mem_dout  out  32  RAM write data (RAM Mdatain).
REQ-016 mem_din  in  32  RAM registered read data (RAM Q), valid one cycle after a read cycle.

Function
REQ-017 The FSM shall have exactly these states: IDLE, RD_ADDR, RD_CAP, WR, DONE.
REQ-018 Acceptance: in IDLE, req=1 at edge N shall latch we, addr and wdata; mem_addr shall take addr from edge N.
REQ-019 Out-of-range: if addr >= ADDR_LIMIT, the FSM shall go IDLE->DONE with err=1, assert no strobe, and leave rdata unchanged.
REQ-020 In-range load: the FSM shall follow IDLE->RD_ADDR->RD_CAP->DONE->IDLE.
  - cycle N+1: RD_ADDR, mem_read=1
  - edge N+2: rdata <= mem_din
  - cycle N+3: DONE, done=1, err=0
REQ-021 In-range store: the FSM shall follow IDLE->WR->DONE->IDLE.
  - cycle N+1: WR, mem_write=1, mem_dout=wdata
  - cycle N+2: DONE, done=1, err=0
REQ-022 mem_read and mem_write shall never be high in the same cycle; each shall be high for exactly one cycle per access.
REQ-023 mem_read and mem_write shall be 0 in all states other than RD_ADDR and WR respectively.
REQ-024 mem_addr and mem_dout shall hold their latched values until the next acceptance.
REQ-025 req shall be ignored in every state except IDLE; a request held high through DONE shall be accepted on the first IDLE edge, giving one idle cycle between accesses.
REQ-026 busy shall equal (state != IDLE).
REQ-027 done and err shall be registered outputs that are high only in DONE.
REQ-028 Address compare shall be unsigned 32-bit; addr = ADDR_LIMIT-1 is valid and addr = ADDR_LIMIT is an error.
REQ-029 addr = 0xFFFFFFFF shall be treated as an error, with no wrap-around.

Reset
REQ-030 While clear=0, every output shall be 0 immediately, independent of clk:
  - state = IDLE
  - busy, done, err, mem_read, mem_write = 0
  - rdata, mem_addr, mem_dout = 0x00000000
REQ-031 Reset asserted mid-access shall abort that access with no done pulse; a store aborted in WR shall drop mem_write asynchronously.
REQ-032 After clear returns to 1, the first edge with req=1 shall be accepted normally.

Verification
REQ-033 Store: req=1, we=1, addr=0x87, wdata=0xDEADBEEF -> next cycle mem_write=1, mem_addr=0x87, mem_dout=0xDEADBEEF; done=1, err=0 one cycle later.
REQ-034 Load: RAM word 0x95 = 0x12345678; req=1, we=0, addr=0x95 -> mem_read=1 for exactly one cycle; done=1 three cycles after acceptance; rdata=0x12345678.
REQ-035 Range boundary:
  - addr=511 load: normal, err=0
  - addr=512 load: done=1 and err=1 one cycle after acceptance, no strobes, rdata unchanged
REQ-036 Back-to-back: req held high for a store then a load to the same address -> strobes never overlap; the load returns the stored value; one idle cycle between accesses.
REQ-037 Reset mid-store: clear=0 while in WR -> mem_write and busy drop to 0 without a clock edge; no done pulse; the next request completes normally.
REQ-038 Busy blocking: toggle req and addr during RD_CAP -> ignored; rdata reflects only the originally latched address.
